// File: rtl/memarb2.sv
// memarb2 -- two-port round-robin arbiter in front of a single memory port.
//
// Port 0 is the host bridge memory master, port 1 is the processor. One
// transaction at a time is forwarded to the memory. The winning request is
// registered for the whole memory cycle, so requester changes made while
// the memory is busy have no effect.
//
// Each transaction walks IDLE -> BUSY -> DONE. BUSY drives the registered
// command to memory until m_waitrequest falls. DONE releases the owner's
// waitrequest for exactly one cycle.
//
// Ports:
//   i_clk, i_reset_n        clock (rising edge), async active-low reset
//   s0_* / s1_*             Avalon-style slave ports (address, read, write,
//                           writedata, readdata, waitrequest)
//   m_*                     Avalon-style master port to the memory
module memarb2 #(
  parameter int unsigned AW = 18,
  parameter int unsigned DW = 36
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  // Port 0: host bridge
  input  logic [AW-1:0] s0_address,
  input  logic          s0_read,
  input  logic          s0_write,
  input  logic [DW-1:0] s0_writedata,
  output logic [DW-1:0] s0_readdata,
  output logic          s0_waitrequest,
  // Port 1: processor
  input  logic [AW-1:0] s1_address,
  input  logic          s1_read,
  input  logic          s1_write,
  input  logic [DW-1:0] s1_writedata,
  output logic [DW-1:0] s1_readdata,
  output logic          s1_waitrequest,
  // Memory side
  output logic [AW-1:0] m_address,
  output logic          m_read,
  output logic          m_write,
  output logic [DW-1:0] m_writedata,
  input  logic [DW-1:0] m_readdata,
  input  logic          m_waitrequest
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          cmd_rd_q, cmd_rd_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic          req0, req1, gnt;
  logic          sel_rd, sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  assign req0 = s0_read | s0_write;
  assign req1 = s1_read | s1_write;

  // A tie goes to the port that was not served last; a lone requester wins.
  assign gnt = (req0 & req1) ? ~last_q : req1;

  always_comb begin
    sel_rd    = gnt ? s1_read      : s0_read;
    sel_wr    = gnt ? s1_write     : s0_write;
    sel_addr  = gnt ? s1_address   : s0_address;
    sel_wdata = gnt ? s1_writedata : s0_writedata;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    cmd_rd_d = cmd_rd_q;
    cmd_wr_d = cmd_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          owner_d  = gnt;
          last_d   = gnt;
          addr_d   = sel_addr;
          wdata_d  = sel_wdata;
          // Read and write together on one port is treated as a write.
          cmd_wr_d = sel_wr;
          cmd_rd_d = sel_rd & ~sel_wr;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (!m_waitrequest) begin
          if (cmd_rd_q) rdata_d = m_readdata;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cmd_rd_q <= 1'b0;
      cmd_wr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cmd_rd_q <= cmd_rd_d;
      cmd_wr_q <= cmd_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Strobes are gated by state so an async reset drops them immediately.
  assign m_read      = (state_q == StBusy) & cmd_rd_q;
  assign m_write     = (state_q == StBusy) & cmd_wr_q;
  assign m_address   = addr_q;
  assign m_writedata = wdata_q;

  assign s0_waitrequest = ~((state_q == StDone) & ~owner_q);
  assign s1_waitrequest = ~((state_q == StDone) & owner_q);
  assign s0_readdata    = rdata_q;
  assign s1_readdata    = rdata_q;

endmodule

// File: tb/tb_memarb2.sv
// Self-checking bench for memarb2: a delay-programmable memory model on the
// master side, a transaction-level reference model of arbitration order and
// memory contents, and directed plus randomized scenarios.
module tb_memarb2;
  localparam int AW = 18;
  localparam int DW = 36;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic [AW-1:0] s0_address, s1_address, m_address;
  logic          s0_read, s0_write, s1_read, s1_write;
  logic [DW-1:0] s0_writedata, s1_writedata, s0_readdata, s1_readdata;
  logic          s0_waitrequest, s1_waitrequest;
  logic          m_read, m_write, m_waitrequest;
  logic [DW-1:0] m_writedata, m_readdata;

  always #5 i_clk = ~i_clk;

  memarb2 #(.AW(AW), .DW(DW)) dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .s0_address     (s0_address),
    .s0_read        (s0_read),
    .s0_write       (s0_write),
    .s0_writedata   (s0_writedata),
    .s0_readdata    (s0_readdata),
    .s0_waitrequest (s0_waitrequest),
    .s1_address     (s1_address),
    .s1_read        (s1_read),
    .s1_write       (s1_write),
    .s1_writedata   (s1_writedata),
    .s1_readdata    (s1_readdata),
    .s1_waitrequest (s1_waitrequest),
    .m_address      (m_address),
    .m_read         (m_read),
    .m_write        (m_write),
    .m_writedata    (m_writedata),
    .m_readdata     (m_readdata),
    .m_waitrequest  (m_waitrequest)
  );

  // Memory model: stalls mem_delay cycles per command, 256 words deep.
  logic [DW-1:0] mem [0:255];
  int            wcnt = 0;
  int            mem_delay = 0;
  logic          bd_we = 1'b0, bd_clr = 1'b0;
  logic [7:0]    bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always @(posedge i_clk) begin
    if (bd_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (m_write && wcnt >= mem_delay) begin
      mem[m_address[7:0]] <= m_writedata;
    end
    if ((m_read || m_write) && wcnt < mem_delay) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  assign m_waitrequest = (m_read || m_write) && (wcnt < mem_delay);
  assign m_readdata    = mem[m_address[7:0]];

  // Reference model state.
  logic [DW-1:0] ref_mem [0:255];
  bit            mdl_last;

  int checks = 0;
  int errors = 0;

  // Results of the last run_txn.
  int            order[$];
  logic [DW-1:0] got0, got1;
  int            rel0, rel1, n_rel0, n_rel1, n_mrd, n_mwr, viol;
  bit            tmo;
  logic [AW-1:0] first_a;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
    @(negedge i_clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge i_clk);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Transaction-level model: serve the requesting ports in arbitration order.
  task automatic model_pair(input bit r0, input bit w0, input logic [AW-1:0] a0,
                            input logic [DW-1:0] d0, input bit r1, input bit w1,
                            input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                            output int first, output logic [DW-1:0] e0,
                            output logic [DW-1:0] e1);
    bit v0, v1;
    int seq[$];
    v0 = r0 | w0;
    v1 = r1 | w1;
    e0 = '0;
    e1 = '0;
    if (v0 && v1) first = mdl_last ? 0 : 1;
    else first = v0 ? 0 : 1;
    seq.push_back(first);
    if (v0 && v1) seq.push_back(1 - first);
    foreach (seq[i]) begin
      if (seq[i] == 0) begin
        if (w0) ref_mem[a0[7:0]] = d0;
        else e0 = ref_mem[a0[7:0]];
      end else begin
        if (w1) ref_mem[a1[7:0]] = d1;
        else e1 = ref_mem[a1[7:0]];
      end
      mdl_last = (seq[i] == 1);
    end
  endtask

  // Drives both requesters until each has been released, recording results.
  task automatic run_txn(input bit r0, input bit w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input bit r1, input bit w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input bit chg0);
    bit p0, p1, prev_busy, seen;
    logic [AW-1:0] prev_a;
    int cyc;
    order.delete();
    got0 = '0; got1 = '0; rel0 = -1; rel1 = -1;
    n_rel0 = 0; n_rel1 = 0; n_mrd = 0; n_mwr = 0; viol = 0; tmo = 1'b0;
    first_a = '0; seen = 1'b0;
    @(negedge i_clk);
    s0_read = r0; s0_write = w0; s0_address = a0; s0_writedata = d0;
    s1_read = r1; s1_write = w1; s1_address = a1; s1_writedata = d1;
    p0 = r0 | w0; p1 = r1 | w1; prev_busy = 1'b0; prev_a = '0; cyc = 0;
    while ((p0 || p1) && cyc < 200) begin
      @(negedge i_clk);
      cyc++;
      if (m_read && m_write) viol++;
      if (m_read) n_mrd++;
      if (m_write) n_mwr++;
      if (prev_busy && (m_read || m_write) && m_address !== prev_a) viol++;
      if ((m_read || m_write) && !seen) begin first_a = m_address; seen = 1'b1; end
      prev_busy = m_read || m_write;
      prev_a = m_address;
      if (!s0_waitrequest) begin
        n_rel0++;
        if (p0) begin
          got0 = s0_readdata; rel0 = cyc; order.push_back(0); p0 = 1'b0;
          s0_read = 1'b0; s0_write = 1'b0;
        end else viol++;
      end
      if (!s1_waitrequest) begin
        n_rel1++;
        if (p1) begin
          got1 = s1_readdata; rel1 = cyc; order.push_back(1); p1 = 1'b0;
          s1_read = 1'b0; s1_write = 1'b0;
        end else viol++;
      end
      if (chg0 && cyc == 1) begin s0_address = a0 + 18'd1; s0_writedata = ~d0; end
    end
    if (p0 || p1) tmo = 1'b1;
    s0_read = 1'b0; s0_write = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      if (!s0_waitrequest) n_rel0++;
      if (!s1_waitrequest) n_rel1++;
      if (m_read || m_write) viol++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (m_read !== 1'b0) begin errors++; $display("FAIL reset_m_read got %b want 0", m_read); end
    checks++; if (m_write !== 1'b0) begin errors++; $display("FAIL reset_m_write got %b want 0", m_write); end
    checks++; if (m_address !== '0) begin errors++; $display("FAIL reset_m_address got %h want 0", m_address); end
    checks++; if (m_writedata !== '0) begin errors++; $display("FAIL reset_m_wdata got %h want 0", m_writedata); end
    checks++; if (s0_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_s0_wr got %b want 1", s0_waitrequest); end
    checks++; if (s1_waitrequest !== 1'b1) begin errors++; $display("FAIL reset_s1_wr got %b want 1", s1_waitrequest); end
    checks++; if (s0_readdata !== '0) begin errors++; $display("FAIL reset_s0_rdata got %h want 0", s0_readdata); end
    checks++; if (s1_readdata !== '0) begin errors++; $display("FAIL reset_s1_rdata got %h want 0", s1_readdata); end
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    bd_clr = 1'b0;
    mdl_last = 1'b1;
  endtask

  task automatic test_single_read();
    int f; logic [DW-1:0] e0, e1;
    preload(8'd4, 36'd123);
    preload(8'd5, 36'd321);
    mem_delay = 0;
    model_pair(1, 0, 18'd4, '0, 0, 0, '0, '0, f, e0, e1);
    run_txn(1, 0, 18'd4, '0, 0, 0, '0, '0, 0);
    checks++; if (got0 !== e0) begin errors++; $display("FAIL single_rdata got %0d want %0d", got0, e0); end
    checks++; if (rel0 !== 2) begin errors++; $display("FAIL single_latency got %0d want 2", rel0); end
    checks++; if (n_mrd !== 1) begin errors++; $display("FAIL single_mread_cycles got %0d want 1", n_mrd); end
    checks++; if (n_mwr !== 0) begin errors++; $display("FAIL single_mwrite_cycles got %0d want 0", n_mwr); end
    checks++; if (n_rel0 !== 1) begin errors++; $display("FAIL single_s0_releases got %0d want 1", n_rel0); end
    checks++; if (n_rel1 !== 0) begin errors++; $display("FAIL single_s1_releases got %0d want 0", n_rel1); end
    checks++; if (first_a !== 18'd4) begin errors++; $display("FAIL single_m_addr got %0d want 4", first_a); end
    checks++; if (viol !== 0 || tmo) begin errors++; $display("FAIL single_protocol viol %0d tmo %0b want 0 0", viol, tmo); end
  endtask

  task automatic test_write_then_read();
    int f; logic [DW-1:0] e0, e1;
    mem_delay = 3;
    model_pair(0, 0, '0, '0, 0, 1, 18'o123, 36'o112233445566, f, e0, e1);
    run_txn(0, 0, '0, '0, 0, 1, 18'o123, 36'o112233445566, 0);
    checks++; if (n_mwr !== 4 || n_mrd !== 0) begin errors++; $display("FAIL wr_strobes got wr %0d rd %0d want 4 0", n_mwr, n_mrd); end
    checks++; if (rel1 !== 5) begin errors++; $display("FAIL wr_latency got %0d want 5", rel1); end
    checks++; if (n_rel1 !== 1 || n_rel0 !== 0) begin errors++; $display("FAIL wr_releases got %0d/%0d want 0/1", n_rel0, n_rel1); end
    model_pair(1, 0, 18'o123, '0, 0, 0, '0, '0, f, e0, e1);
    run_txn(1, 0, 18'o123, '0, 0, 0, '0, '0, 0);
    checks++; if (got0 !== e0) begin errors++; $display("FAIL rd_after_wr got %o want %o", got0, e0); end
    checks++; if (rel0 !== 5) begin errors++; $display("FAIL rd_after_wr_latency got %0d want 5", rel0); end
  endtask

  task automatic test_both_read();
    int f; logic [DW-1:0] e0, e1;
    mem_delay = 0;
    for (int k = 0; k < 4; k++) begin
      model_pair(1, 0, 18'd4, '0, 1, 0, 18'd5, '0, f, e0, e1);
      run_txn(1, 0, 18'd4, '0, 1, 0, 18'd5, '0, 0);
      checks++; if (order.size() !== 2 || order[0] !== f || order[1] !== 1 - f) begin
        errors++; $display("FAIL both_order iter %0d got first %0d want %0d", k, order[0], f); end
      checks++; if (got0 !== e0 || got1 !== e1) begin
        errors++; $display("FAIL both_rdata got %0d/%0d want %0d/%0d", got0, got1, e0, e1); end
      checks++; if ((f == 0 ? rel0 : rel1) !== 2 || (f == 0 ? rel1 : rel0) !== 5) begin
        errors++; $display("FAIL both_timing got %0d/%0d want first 2 second 5", rel0, rel1); end
      checks++; if (viol !== 0 || tmo) begin errors++; $display("FAIL both_protocol viol %0d tmo %0b want 0 0", viol, tmo); end
    end
  endtask

  task automatic test_addr_change();
    int f; logic [DW-1:0] e0, e1;
    mem_delay = 2;
    model_pair(1, 0, 18'd4, '0, 0, 0, '0, '0, f, e0, e1);
    run_txn(1, 0, 18'd4, '0, 0, 0, '0, '0, 1);
    checks++; if (got0 !== e0) begin errors++; $display("FAIL chg_rdata got %0d want %0d", got0, e0); end
    checks++; if (first_a !== 18'd4) begin errors++; $display("FAIL chg_m_addr got %0d want 4", first_a); end
    checks++; if (viol !== 0 || rel0 !== 4) begin errors++; $display("FAIL chg_protocol viol %0d lat %0d want 0 4", viol, rel0); end
  endtask

  task automatic test_rw_both();
    int f; logic [DW-1:0] e0, e1;
    mem_delay = 1;
    model_pair(0, 0, '0, '0, 1, 1, 18'o10, 36'd7, f, e0, e1);
    run_txn(0, 0, '0, '0, 1, 1, 18'o10, 36'd7, 0);
    checks++; if (n_mwr !== 2 || n_mrd !== 0) begin errors++; $display("FAIL rw_strobes got wr %0d rd %0d want 2 0", n_mwr, n_mrd); end
    checks++; if (n_rel1 !== 1) begin errors++; $display("FAIL rw_releases got %0d want 1", n_rel1); end
    model_pair(1, 0, 18'o10, '0, 0, 0, '0, '0, f, e0, e1);
    run_txn(1, 0, 18'o10, '0, 0, 0, '0, '0, 0);
    checks++; if (got0 !== e0) begin errors++; $display("FAIL rw_readback got %0d want %0d", got0, e0); end
  endtask

  task automatic test_reset_busy();
    int f; logic [DW-1:0] e0, e1;
    mem_delay = 1000;
    @(negedge i_clk);
    s0_read = 1'b1; s0_address = 18'd4;
    repeat (3) @(negedge i_clk);
    checks++; if (m_read !== 1'b1) begin errors++; $display("FAIL rstbusy_pre_m_read got %b want 1", m_read); end
    #2 i_reset_n = 1'b0;
    #1;
    checks++; if (m_read !== 1'b0 || m_write !== 1'b0) begin
      errors++; $display("FAIL rstbusy_strobes got %b%b want 00", m_read, m_write); end
    checks++; if (s0_waitrequest !== 1'b1 || s1_waitrequest !== 1'b1) begin
      errors++; $display("FAIL rstbusy_wr got %b%b want 11", s0_waitrequest, s1_waitrequest); end
    checks++; if (s0_readdata !== '0) begin errors++; $display("FAIL rstbusy_rdata got %h want 0", s0_readdata); end
    s0_read = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    mem_delay = 0;
    mdl_last = 1'b1;
    model_pair(1, 0, 18'd4, '0, 1, 0, 18'd5, '0, f, e0, e1);
    run_txn(1, 0, 18'd4, '0, 1, 0, 18'd5, '0, 0);
    checks++; if (order.size() !== 2 || order[0] !== f) begin
      errors++; $display("FAIL rstbusy_order got %0d want %0d", order[0], f); end
    checks++; if (got0 !== e0 || rel0 !== 2) begin
      errors++; $display("FAIL rstbusy_after got %0d lat %0d want %0d 2", got0, rel0, e0); end
  endtask

  task automatic test_random();
    int f, c0, c1, d, lat_f, lat_s;
    bit r0, w0, r1, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1, e0, e1;
    logic [63:0] tmp;
    for (int it = 0; it < 40; it++) begin
      d = $urandom_range(0, 3);
      mem_delay = d;
      c0 = $urandom_range(0, 3);
      c1 = $urandom_range(0, 3);
      if (c0 == 3 && c1 == 3) c0 = 0;
      r0 = (c0 == 0 || c0 == 2); w0 = (c0 == 1 || c0 == 2);
      r1 = (c1 == 0 || c1 == 2); w1 = (c1 == 1 || c1 == 2);
      a0 = 18'($urandom_range(0, 7));
      a1 = 18'($urandom_range(0, 7));
      tmp = {$urandom(), $urandom()}; d0 = tmp[DW-1:0];
      tmp = {$urandom(), $urandom()}; d1 = tmp[DW-1:0];
      model_pair(r0, w0, a0, d0, r1, w1, a1, d1, f, e0, e1);
      run_txn(r0, w0, a0, d0, r1, w1, a1, d1, 0);
      lat_f = 2 + d;
      lat_s = 5 + 2 * d;
      checks++; if (viol !== 0 || tmo) begin
        errors++; $display("FAIL rand_protocol it %0d viol %0d tmo %0b want 0 0", it, viol, tmo); end
      checks++; if (order.size() < 1 || order[0] !== f) begin
        errors++; $display("FAIL rand_order it %0d got %0d want %0d", it, order[0], f); end
      if (r0 && !w0) begin
        checks++; if (got0 !== e0) begin errors++; $display("FAIL rand_rdata0 it %0d got %h want %h", it, got0, e0); end
      end
      if (r1 && !w1) begin
        checks++; if (got1 !== e1) begin errors++; $display("FAIL rand_rdata1 it %0d got %h want %h", it, got1, e1); end
      end
      if ((r0 | w0) && (r1 | w1)) begin
        checks++; if ((f == 0 ? rel0 : rel1) !== lat_f || (f == 0 ? rel1 : rel0) !== lat_s) begin
          errors++; $display("FAIL rand_timing it %0d got %0d/%0d want %0d/%0d", it, rel0, rel1,
                             f == 0 ? lat_f : lat_s, f == 0 ? lat_s : lat_f); end
      end else begin
        checks++; if ((f == 0 ? rel0 : rel1) !== lat_f) begin
          errors++; $display("FAIL rand_timing1 it %0d got %0d/%0d want %0d", it, rel0, rel1, lat_f); end
      end
    end
  endtask

  initial begin
    s0_address = '0; s0_read = 1'b0; s0_write = 1'b0; s0_writedata = '0;
    s1_address = '0; s1_read = 1'b0; s1_write = 1'b0; s1_writedata = '0;
    bd_clr = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    mdl_last = 1'b1;
    test_reset();
    test_single_read();
    test_write_then_read();
    test_both_read();
    test_addr_change();
    test_rw_both();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
